// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, one or two stop bits, fixed clk-count bit timing.
// A one-entry holding register lets the producer queue the next byte so frames run back-to-back.
module uart_transmitter #(
    parameter int unsigned BIT_INTERVAL = 10000,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       uart_tx,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic LAST_STOP = (STOP_BITS == 32'd2);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop_q, stop_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        tx_q, tx_d;
    logic        transfer;
    logic        cnt_last;

    assign ready    = !reset && !hold_valid_q;
    assign transfer = valid && ready;
    assign busy     = (state_q != IDLE) || hold_valid_q;
    assign uart_tx  = tx_q;
    assign cnt_last = (cnt_q + 32'd1) >= BIT_INTERVAL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            bit_q        <= 3'd0;
            stop_q       <= 1'b0;
            shift_q      <= 8'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_d         = tx_q;

        // A transfer mid-frame can only happen while hold is empty, so it never races a drain.
        if (transfer && (state_q != IDLE)) begin
            hold_d       = data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    state_d      = START;
                    cnt_d        = 32'd0;
                    tx_d         = 1'b0;
                end else if (transfer) begin
                    shift_d = data;
                    state_d = START;
                    cnt_d   = 32'd0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_last) begin
                    state_d = DATA;
                    cnt_d   = 32'd0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = 32'd0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d = 32'd0;
                    if (stop_q == LAST_STOP) begin
                        if (hold_valid_q) begin
                            shift_d      = hold_q;
                            hold_valid_d = 1'b0;
                            state_d      = START;
                            tx_d         = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule
